// File: rtl/operand_loader_if.sv
// operand_loader_if
//   Groups the operand-loader user inputs (buttons, switches) and the
//   registered operand/status outputs that feed the adder.
//   master : drives buttons and switches, observes operands/status
//   slave  : the operand_loader itself
interface operand_loader_if;
  logic       btn_load;   // raw load pushbutton
  logic       btn_clear;  // raw clear pushbutton
  logic [3:0] sw;         // operand value switches
  logic       sw_cin;     // carry-in switch
  logic [3:0] A;          // registered operand A
  logic [3:0] B;          // registered operand B
  logic       c_in;       // registered carry-in
  logic       a_valid;    // A holds a loaded value
  logic       b_valid;    // B/c_in hold loaded values
  logic       ready;      // both operands loaded
  logic [1:0] state;      // 00 LOAD_A, 01 LOAD_B, 10 READY

  modport master (
    output btn_load, btn_clear, sw, sw_cin,
    input  A, B, c_in, a_valid, b_valid, ready, state
  );

  modport slave (
    input  btn_load, btn_clear, sw, sw_cin,
    output A, B, c_in, a_valid, b_valid, ready, state
  );
endinterface

// File: rtl/operand_loader.sv
// operand_loader
//   Operand-capture stage for the 4-bit adder. Each raw pushbutton is
//   synchronised, debounced and edge-detected into a one-cycle press pulse.
//   Load presses latch A, then B with c_in; clear presses empty everything.
// Ports
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : operand_loader_if.slave (buttons, switches, operands, status)
module operand_loader #(
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20
) (
  input logic              clk,
  input logic              rst,
  operand_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    READY  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES - 1);

  // bit 0 = load button, bit 1 = clear button
  logic [1:0]       raw_s;
  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  logic [1:0]       deb_r;
  logic [1:0]       deb_d_r;
  logic [1:0]       pulse_r;
  logic [CNT_W-1:0] cnt_r [2];

  state_t     state_r, state_next_s;
  logic [3:0] a_r, a_next_s;
  logic [3:0] b_r, b_next_s;
  logic       cin_r, cin_next_s;
  logic       av_r, av_next_s;
  logic       bv_r, bv_next_s;
  logic       ready_r;
  logic       load_s;
  logic       clr_s;

  assign raw_s = {bus.btn_clear, bus.btn_load};

  // Button front end: 2-flop synchroniser, debounce counter, rise-edge pulse.
  // A bounce back to the accepted level zeroes the counter, so only a level
  // that stays different for DB_CYCLES consecutive cycles is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
      deb_r   <= 2'b00;
      deb_d_r <= 2'b00;
      pulse_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      pulse_r <= deb_r & ~deb_d_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          cnt_r[i] <= CNT_ZERO;
        end else if (cnt_r[i] == CNT_MAX) begin
          deb_r[i] <= sync2_r[i];
          cnt_r[i] <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  assign load_s = pulse_r[0];
  assign clr_s  = pulse_r[1];

  // Sequencer next-state and next-register values; clear has priority.
  always_comb begin
    state_next_s = state_r;
    a_next_s     = a_r;
    b_next_s     = b_r;
    cin_next_s   = cin_r;
    av_next_s    = av_r;
    bv_next_s    = bv_r;
    if (clr_s) begin
      state_next_s = LOAD_A;
      a_next_s     = 4'h0;
      b_next_s     = 4'h0;
      cin_next_s   = 1'b0;
      av_next_s    = 1'b0;
      bv_next_s    = 1'b0;
    end else begin
      case (state_r)
        LOAD_A: begin
          if (load_s) begin
            a_next_s     = bus.sw;
            av_next_s    = 1'b1;
            state_next_s = LOAD_B;
          end else begin
            state_next_s = LOAD_A;
          end
        end
        LOAD_B: begin
          if (load_s) begin
            b_next_s     = bus.sw;
            cin_next_s   = bus.sw_cin;
            bv_next_s    = 1'b1;
            state_next_s = READY;
          end else begin
            state_next_s = LOAD_B;
          end
        end
        READY: begin
          // A new load starts the next operation with a fresh A
          if (load_s) begin
            a_next_s     = bus.sw;
            b_next_s     = 4'h0;
            cin_next_s   = 1'b0;
            bv_next_s    = 1'b0;
            state_next_s = LOAD_B;
          end else begin
            state_next_s = READY;
          end
        end
        default: begin
          // Unused encoding recovers like a clear
          state_next_s = LOAD_A;
          a_next_s     = 4'h0;
          b_next_s     = 4'h0;
          cin_next_s   = 1'b0;
          av_next_s    = 1'b0;
          bv_next_s    = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state and operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= LOAD_A;
      a_r     <= 4'h0;
      b_r     <= 4'h0;
      cin_r   <= 1'b0;
      av_r    <= 1'b0;
      bv_r    <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      a_r     <= a_next_s;
      b_r     <= b_next_s;
      cin_r   <= cin_next_s;
      av_r    <= av_next_s;
      bv_r    <= bv_next_s;
      ready_r <= (state_next_s == READY);
    end
  end

  assign bus.A       = a_r;
  assign bus.B       = b_r;
  assign bus.c_in    = cin_r;
  assign bus.a_valid = av_r;
  assign bus.b_valid = bv_r;
  assign bus.ready   = ready_r;
  assign bus.state   = state_r;

endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader
//   Drives operand_loader with directed scenarios and random button/switch
//   activity, comparing every cycle against a behavioural model that works
//   from "raw level seen two cycles late, stable for DB samples" rules.
module tb_operand_loader;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  operand_loader_if bus_if();

  operand_loader #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
  endtask

  // ---------------- behavioural model ----------------
  int m_A = 0, m_B = 0, m_cin = 0, m_av = 0, m_bv = 0, m_state = 0, m_ready = 0;
  bit m_r1 [2];
  bit m_r2 [2];
  bit m_deb [2];
  bit m_rose [2];
  bit m_pulse [2];
  bit m_win [2][DB];
  int m_nseen [2];

  task automatic m_clear_ops();
    m_A = 0; m_B = 0; m_cin = 0; m_av = 0; m_bv = 0; m_state = 0;
  endtask

  task automatic m_reset();
    m_clear_ops();
    m_ready = 0;
    for (int b = 0; b < 2; b++) begin
      m_r1[b] = 1'b0; m_r2[b] = 1'b0; m_deb[b] = 1'b0;
      m_rose[b] = 1'b0; m_pulse[b] = 1'b0; m_nseen[b] = 0;
      for (int k = 0; k < DB; k++) m_win[b][k] = 1'b0;
    end
  endtask

  task automatic m_step();
    bit raw [2];
    bit obs;
    bit all_diff;
    raw[0] = bus_if.btn_load;
    raw[1] = bus_if.btn_clear;
    // operand sequencing using presses that are visible this cycle
    if (m_pulse[1]) m_clear_ops();
    else if (m_pulse[0]) begin
      if (m_state == 0) begin
        m_A = int'(bus_if.sw); m_av = 1; m_state = 1;
      end else if (m_state == 1) begin
        m_B = int'(bus_if.sw); m_cin = int'(bus_if.sw_cin); m_bv = 1; m_state = 2;
      end else begin
        m_A = int'(bus_if.sw); m_B = 0; m_cin = 0; m_bv = 0; m_state = 1;
      end
    end
    m_ready = (m_state == 2) ? 1 : 0;
    // button level tracking: press is visible one cycle after acceptance
    for (int b = 0; b < 2; b++) begin
      m_pulse[b] = m_rose[b];
      obs = m_r2[b];
      m_r2[b] = m_r1[b];
      m_r1[b] = raw[b];
      for (int k = DB - 1; k > 0; k--) m_win[b][k] = m_win[b][k-1];
      m_win[b][0] = obs;
      if (m_nseen[b] < DB) m_nseen[b]++;
      all_diff = (m_nseen[b] >= DB);
      for (int k = 0; k < DB; k++) if (m_win[b][k] == m_deb[b]) all_diff = 1'b0;
      m_rose[b] = 1'b0;
      if (all_diff) begin
        m_deb[b] = obs;
        m_rose[b] = obs;
      end
    end
  endtask

  initial m_reset();

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else m_step();
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("A",       int'(bus_if.A),       m_A);
    check("B",       int'(bus_if.B),       m_B);
    check("c_in",    int'(bus_if.c_in),    m_cin);
    check("a_valid", int'(bus_if.a_valid), m_av);
    check("b_valid", int'(bus_if.b_valid), m_bv);
    check("ready",   int'(bus_if.ready),   m_ready);
    check("state",   int'(bus_if.state),   m_state);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press_load(input logic [3:0] v, input logic cin);
    bus_if.sw = v; bus_if.sw_cin = cin;
    bus_if.btn_load = 1'b1;
    cyc(10);
    bus_if.btn_load = 1'b0;
    cyc(12);
  endtask

  initial begin
    bus_if.btn_load = 1'b0;
    bus_if.btn_clear = 1'b0;
    bus_if.sw = 4'h0;
    bus_if.sw_cin = 1'b0;
    #1 rst = 1'b1;
    cyc(3);
    rst = 1'b0;

    // 1: reset state, idle buttons give nothing
    check("t1_state", int'(bus_if.state), 0);
    check("t1_A", int'(bus_if.A), 0);
    cyc(10);
    check("t1_idle_state", int'(bus_if.state), 0);
    check("t1_idle_avalid", int'(bus_if.a_valid), 0);

    // 2: clean press captures A exactly 8 edges after the raw edge
    bus_if.sw = 4'h5;
    bus_if.btn_load = 1'b1;
    cyc(7);
    check("t2_before_state", int'(bus_if.state), 0);
    cyc(1);
    check("t2_at8_state", int'(bus_if.state), 1);
    check("t2_at8_A", int'(bus_if.A), 5);
    check("t2_model_A", m_A, 5);
    cyc(2);
    bus_if.btn_load = 1'b0;
    bus_if.sw = 4'hF;
    cyc(12);
    check("t2_A_held", int'(bus_if.A), 5);
    press_load(4'hA, 1'b1);
    check("t2_B", int'(bus_if.B), 10);
    check("t2_cin", int'(bus_if.c_in), 1);
    check("t2_ready", int'(bus_if.ready), 1);
    check("t2_state", int'(bus_if.state), 2);
    check("t2_model_state", m_state, 2);

    // 3: bouncing press gives exactly one capture
    bus_if.sw = 4'h9;
    bus_if.sw_cin = 1'b0;
    bus_if.btn_load = 1'b1; cyc(2);
    bus_if.btn_load = 1'b0; cyc(2);
    bus_if.btn_load = 1'b1; cyc(2);
    bus_if.btn_load = 1'b0; cyc(2);
    bus_if.btn_load = 1'b1;
    cyc(2 + DB);
    check("t3_not_yet", int'(bus_if.state), 2);
    cyc(50);
    check("t3_state", int'(bus_if.state), 1);
    check("t3_A", int'(bus_if.A), 9);
    bus_if.btn_load = 1'b0;
    cyc(12);
    press_load(4'hC, 1'b1);
    check("t3_ready", int'(bus_if.ready), 1);

    // 4: load from READY starts a new operation
    press_load(4'h3, 1'b1);
    check("t4_A", int'(bus_if.A), 3);
    check("t4_B", int'(bus_if.B), 0);
    check("t4_cin", int'(bus_if.c_in), 0);
    check("t4_bvalid", int'(bus_if.b_valid), 0);
    check("t4_ready", int'(bus_if.ready), 0);
    check("t4_state", int'(bus_if.state), 1);

    // 5: simultaneous load and clear, clear wins
    bus_if.btn_load = 1'b1;
    bus_if.btn_clear = 1'b1;
    cyc(10);
    bus_if.btn_load = 1'b0;
    bus_if.btn_clear = 1'b0;
    cyc(12);
    check("t5_state", int'(bus_if.state), 0);
    check("t5_A", int'(bus_if.A), 0);
    check("t5_avalid", int'(bus_if.a_valid), 0);
    check("t5_model_av", m_av, 0);

    // 6: reset mid-debounce aborts at once and leaves no pending press
    press_load(4'h7, 1'b0);
    check("t6_pre_A", int'(bus_if.A), 7);
    bus_if.btn_load = 1'b1;
    cyc(4);
    rst = 1'b1;
    #1;
    check("t6_rst_A", int'(bus_if.A), 0);
    check("t6_rst_avalid", int'(bus_if.a_valid), 0);
    check("t6_rst_state", int'(bus_if.state), 0);
    bus_if.btn_load = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(20);
    check("t6_after_state", int'(bus_if.state), 0);
    check("t6_after_avalid", int'(bus_if.a_valid), 0);

    // random activity against the model
    for (int it = 0; it < 300; it++) begin
      int hold;
      bus_if.btn_load  = ($urandom_range(0, 2) != 0);
      bus_if.btn_clear = ($urandom_range(0, 5) == 0);
      hold = $urandom_range(1, 12);
      for (int c = 0; c < hold; c++) begin
        bus_if.sw = 4'($urandom_range(0, 15));
        bus_if.sw_cin = 1'($urandom_range(0, 1));
        cyc(1);
      end
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        cyc($urandom_range(1, 2));
        rst = 1'b0;
      end
    end
    bus_if.btn_load = 1'b0;
    bus_if.btn_clear = 1'b0;
    cyc(12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
